// File: rtl/hack_kbd_pkg.sv
// Shared constants, types and scancode mapping for the PS/2 keyboard front end.
// Optional feature macro: PS2_SHIFT_EN (Shift tracking, lowercase and shifted ASCII).
package hack_kbd_pkg;

    // Hack special-key codes
    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F12       = 8'd152;

    // Set-2 prefix and modifier scancodes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Bytes following E1 that belong to the Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

`ifdef PS2_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // shiftable marks main-block keys whose character changes with Shift
    typedef struct packed {
        logic       shiftable;
        logic [7:0] code;
    } hack_map_t;

    // key = {extended, scancode}; code 0 means the key is unmapped
    function automatic hack_map_t hack_map(input logic [8:0] key);
        hack_map_t m;
        m.code      = 8'd0;
        m.shiftable = 1'b0;
        case (key)
            9'h01C: m.code = "A";   9'h032: m.code = "B";   9'h021: m.code = "C";
            9'h023: m.code = "D";   9'h024: m.code = "E";   9'h02B: m.code = "F";
            9'h034: m.code = "G";   9'h033: m.code = "H";   9'h043: m.code = "I";
            9'h03B: m.code = "J";   9'h042: m.code = "K";   9'h04B: m.code = "L";
            9'h03A: m.code = "M";   9'h031: m.code = "N";   9'h044: m.code = "O";
            9'h04D: m.code = "P";   9'h015: m.code = "Q";   9'h02D: m.code = "R";
            9'h01B: m.code = "S";   9'h02C: m.code = "T";   9'h03C: m.code = "U";
            9'h02A: m.code = "V";   9'h01D: m.code = "W";   9'h022: m.code = "X";
            9'h035: m.code = "Y";   9'h01A: m.code = "Z";
            9'h016: m.code = "1";   9'h01E: m.code = "2";   9'h026: m.code = "3";
            9'h025: m.code = "4";   9'h02E: m.code = "5";   9'h036: m.code = "6";
            9'h03D: m.code = "7";   9'h03E: m.code = "8";   9'h046: m.code = "9";
            9'h045: m.code = "0";   9'h029: m.code = " ";   9'h00E: m.code = 8'd96;
            9'h04E: m.code = "-";   9'h055: m.code = "=";   9'h054: m.code = "[";
            9'h05B: m.code = "]";   9'h05D: m.code = 8'd92; 9'h04C: m.code = ";";
            9'h052: m.code = 8'd39; 9'h041: m.code = ",";   9'h049: m.code = ".";
            9'h04A: m.code = "/";
            default: m.code = 8'd0;
        endcase
        if (m.code != 8'd0) begin
            m.shiftable = 1'b1;
        end else begin
            case (key)
                9'h05A, 9'h15A: m.code = KEY_NEWLINE;
                9'h066: m.code = KEY_BACKSPACE;
                9'h16B: m.code = KEY_LEFT;    9'h175: m.code = KEY_UP;
                9'h174: m.code = KEY_RIGHT;   9'h172: m.code = KEY_DOWN;
                9'h16C: m.code = KEY_HOME;    9'h169: m.code = KEY_END;
                9'h17D: m.code = KEY_PGUP;    9'h17A: m.code = KEY_PGDN;
                9'h170: m.code = KEY_INSERT;  9'h171: m.code = KEY_DELETE;
                9'h076: m.code = KEY_ESC;
                9'h005: m.code = KEY_F1;      9'h006: m.code = 8'd142;
                9'h004: m.code = 8'd143;      9'h00C: m.code = 8'd144;
                9'h003: m.code = 8'd145;      9'h00B: m.code = 8'd146;
                9'h083: m.code = 8'd147;      9'h00A: m.code = 8'd148;
                9'h001: m.code = 8'd149;      9'h009: m.code = 8'd150;
                9'h078: m.code = 8'd151;      9'h007: m.code = KEY_F12;
                // Keypad keys report their ASCII glyph and ignore Shift
                9'h070: m.code = "0";   9'h069: m.code = "1";   9'h072: m.code = "2";
                9'h07A: m.code = "3";   9'h06B: m.code = "4";   9'h073: m.code = "5";
                9'h074: m.code = "6";   9'h06C: m.code = "7";   9'h075: m.code = "8";
                9'h07D: m.code = "9";   9'h071: m.code = ".";   9'h07C: m.code = "*";
                9'h07B: m.code = "-";   9'h079: m.code = "+";   9'h14A: m.code = "/";
                default: m.code = 8'd0;
            endcase
        end
        return m;
    endfunction

    // US-layout shifted character of a main-block key; letters stay uppercase
    function automatic logic [7:0] shift_ascii(input logic [7:0] c);
        case (c)
            "1": return "!";   "2": return "@";   "3": return "#";   "4": return "$";
            "5": return "%";   "6": return "^";   "7": return "&";   "8": return "*";
            "9": return "(";   "0": return ")";   8'd96: return "~"; "-": return "_";
            "=": return "+";   "[": return "{";   "]": return "}";   8'd92: return 8'd124;
            ";": return ":";   8'd39: return 8'd34; ",": return "<"; ".": return ">";
            "/": return "?";
            default: return c;
        endcase
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronisers, clock glitch filter, frame FSM
// with mid-frame timeout. Emits one byte_valid pulse per good frame.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic          clk_p0, clk_p1, dat_p0, dat_p1;
    logic          flt_clk;
    logic [FW-1:0] flt_cnt;
    logic          flt_flip, fall;
    rx_state_t     state, next_state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          timeout, good_c, err_c;

    // Two-flop synchronisers; both lines idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
        end
    end

    // Level filter: the filtered clock follows only after FILTER_LEN differing samples
    assign flt_flip = (clk_p1 != flt_clk) && (flt_cnt == FW'(FILTER_LEN - 1));
    assign fall     = flt_flip && flt_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flt_clk <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_p1 == flt_clk) begin
            flt_cnt <= '0;
        end else if (flt_flip) begin
            flt_clk <= clk_p1;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // A fall in the same cycle suppresses the timeout
    assign timeout = (state != RX_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else       state <= next_state;
    end

    // Frame FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:   if (fall && !dat_p1) next_state = RX_DATA;
            RX_DATA:   if (fall && bit_cnt == 3'd7) next_state = RX_PARITY;
                       else if (timeout)            next_state = RX_IDLE;
            RX_PARITY: if (fall || timeout) next_state = (fall ? RX_STOP : RX_IDLE);
            RX_STOP:   if (fall || timeout) next_state = RX_IDLE;
            default:   next_state = RX_IDLE;
        endcase
    end

    // Frame FSM outputs: good frame needs odd parity and a high stop bit
    always_comb begin
        good_c = (state == RX_STOP) && fall && dat_p1 && (^{shift_q, par_q});
        err_c  = timeout
               || ((state == RX_IDLE) && fall && dat_p1)
               || ((state == RX_STOP) && fall && !(dat_p1 && (^{shift_q, par_q})));
    end

    // Bit counter, timeout counter and registered status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= good_c;
            frame_err  <= err_c;
            if (state == RX_IDLE)            bit_cnt <= 3'd0;
            else if (state == RX_DATA && fall) bit_cnt <= bit_cnt + 3'd1;
            if (state == RX_IDLE || fall)    to_cnt <= '0;
            else                             to_cnt <= to_cnt + 1'b1;
        end
    end

    // Data path: LSB-first shift, parity capture, byte hand-off
    always_ff @(posedge clk) begin
        if (state == RX_DATA && fall)   shift_q <= {dat_p1, shift_q[7:1]};
        if (state == RX_PARITY && fall) par_q   <= dat_p1;
        if (good_c)                     rx_byte <= shift_q;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end for the Hack memory-mapped keyboard word.
// Decodes set-2 make/break/extended/Pause sequences into Hack key codes.
// Optional feature macro: PS2_SHIFT_EN (Shift tracking, lowercase and shifted ASCII).
module ps2_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kb,
    output logic        key_strobe,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       ext_q, brk_q, last_vld;
    logic [2:0] skip_q;
    logic [8:0] key_c, last_key;
    logic [7:0] code_c, kb_lo;
    logic       is_prefix, key_byte, shift_held;
    hack_map_t  map_c;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_byte_valid),
        .frame_err  (frame_err)
    );

    assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK) || (rx_byte == SC_PAUSE);
    assign key_byte  = rx_byte_valid && (skip_q == 3'd0) && !is_prefix;
    assign key_c     = {ext_q, rx_byte};
    assign kb        = {8'h00, kb_lo};

    // Scancode to Hack code, with Shift applied to main-block keys when enabled
    always_comb begin
        map_c  = hack_map(key_c);
        code_c = map_c.code;
        if (SHIFT_EN && map_c.shiftable)
            code_c = shift_held ? shift_ascii(map_c.code) : to_lower(map_c.code);
    end

`ifdef PS2_SHIFT_EN
    logic shift_lq, shift_rq;

    // Track both Shift keys; they are unmapped so kb never reports them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_lq <= 1'b0;
            shift_rq <= 1'b0;
        end else if (key_byte && !ext_q) begin
            if (rx_byte == SC_LSHIFT) shift_lq <= !brk_q;
            if (rx_byte == SC_RSHIFT) shift_rq <= !brk_q;
        end
    end

    assign shift_held = shift_lq || shift_rq;
`else
    assign shift_held = 1'b0;
`endif

    // Prefix tracking, Pause skipping and kb update on each received byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_lo      <= 8'd0;
            key_strobe <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= 3'd0;
            last_key   <= 9'd0;
            last_vld   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_byte_valid) begin
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 3'd1;
                end else if (rx_byte == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_q <= 1'b1;
                end else if (rx_byte == SC_PAUSE) begin
                    skip_q <= PAUSE_SKIP;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (code_c != 8'd0) begin
                        if (!brk_q) begin
                            kb_lo      <= code_c;
                            last_key   <= key_c;
                            last_vld   <= 1'b1;
                            key_strobe <= 1'b1;
                        end else if (last_vld && key_c == last_key) begin
                            // Releasing an older key of a rollover keeps the newer one
                            kb_lo    <= 8'd0;
                            last_vld <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: stimulus pushes expected events,
// a negedge monitor pops and compares each strobe, kb change and frame_err.
module tb_ps2_keyboard;

    localparam int FLT = 8;
    localparam int TMO = 1500;
    localparam int H   = 20;
    localparam int GAP = 60;

    localparam logic [1:0] EV_STROBE = 2'd0;
    localparam logic [1:0] EV_CHG    = 2'd1;
    localparam logic [1:0] EV_ERR    = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kb;
    logic        key_strobe, frame_err;

    ev_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          bv_cyc = -100;
    logic [15:0] prev_kb = 16'd0;
    bit          mon_en = 1'b0;

    ps2_keyboard #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kb         (kb),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input logic [1:0] kind, input logic [15:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d kb=%0d expected no event at cycle %0d", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                failures++;
                $display("FAIL event: got kind=%0d kb=%0d expected kind=%0d kb=%0d at cycle %0d",
                         kind, val, e.kind, e.val, cyc);
            end
        end
    endtask

    // Monitor: classify DUT activity each cycle and compare against the scoreboard
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_kb = kb;
        end else begin
            if (key_strobe)         got_ev(EV_STROBE, kb);
            else if (kb !== prev_kb) got_ev(EV_CHG, kb);
            if (key_strobe || kb !== prev_kb)
                chk("kb_latency_after_byte_valid", 16'(cyc - bv_cyc), 16'd1);
            if (frame_err) got_ev(EV_ERR, 16'd0);
            if (dut.rx_byte_valid) bv_cyc = cyc;
            prev_kb = kb;
        end
    end

    // One PS/2 frame, device to host; nbits < 11 sends a truncated frame
    task automatic send(input logic [7:0] b, input bit bad_par = 1'b0,
                        input bit bad_stop = 1'b0, input int nbits = 11);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic chk_kb(input string name, input logic [15:0] exp);
        @(negedge clk);
        chk(name, kb, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_kb", kb, 16'd0);
        chk("reset_key_strobe", {15'd0, key_strobe}, 16'd0);
        chk("reset_frame_err", {15'd0, frame_err}, 16'd0);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        mon_en = 1'b1;

        // Make and break of A
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        chk_kb("a_make", 16'd65);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h1C);
        chk_kb("a_break", 16'd0);

        // Extended Up versus keypad 8
        expect_ev(EV_STROBE, 16'd131);
        send(8'hE0); send(8'h75);
        chk_kb("up_make", 16'd131);
        expect_ev(EV_CHG, 16'd0);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev(EV_STROBE, 16'd56);
        send(8'h75);
        chk_kb("keypad8_make", 16'd56);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h75);

        // Rollover A then B
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        expect_ev(EV_STROBE, 16'd66);
        send(8'h32);
        send(8'hF0); send(8'h1C);
        chk_kb("rollover_hold_b", 16'd66);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h32);

        // Auto-repeat strobes again
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h1C);

        // Parity error, stop-bit error, stray fall while idle
        expect_ev(EV_ERR, 16'd0);
        send(8'h1C, 1'b1);
        chk_kb("bad_parity_kb", 16'd0);
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h1C);
        expect_ev(EV_ERR, 16'd0);
        send(8'h32, 1'b0, 1'b1);
        chk_kb("bad_stop_kb", 16'd0);
        expect_ev(EV_ERR, 16'd0);
        ps2_clk = 1'b0;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(posedge clk);

        // Mid-frame timeout then a good space
        expect_ev(EV_ERR, 16'd0);
        send(8'h1C, 1'b0, 1'b0, 5);
        repeat (TMO + 200) @(posedge clk);
        expect_ev(EV_STROBE, 16'd32);
        send(8'h29);
        chk_kb("space_after_timeout", 16'd32);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h29);

        // Unmapped key (Tab) is ignored
        send(8'h0D); send(8'hF0); send(8'h0D);
        chk_kb("unmapped_tab", 16'd0);

        // F12 then Esc; releasing F12 keeps Esc
        expect_ev(EV_STROBE, 16'd152);
        send(8'h07);
        expect_ev(EV_STROBE, 16'd140);
        send(8'h76);
        send(8'hF0); send(8'h07);
        chk_kb("esc_held", 16'd140);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h76);

        // Pause sequence leaves a held key alone
        expect_ev(EV_STROBE, 16'd65);
        send(8'h1C);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk_kb("pause_kb_unchanged", 16'd65);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h1C);

        // Shift handling
        expect_ev(EV_STROBE, 16'd65);
        send(8'h12); send(8'h1C);
        send(8'hF0); send(8'h12);
`ifdef PS2_SHIFT_EN
        expect_ev(EV_STROBE, 16'd97);
`else
        expect_ev(EV_STROBE, 16'd65);
`endif
        send(8'h1C);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h1C);
`ifdef PS2_SHIFT_EN
        expect_ev(EV_STROBE, 16'd33);
`else
        expect_ev(EV_STROBE, 16'd49);
`endif
        send(8'h12); send(8'h16);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h12);

        // Reset in the middle of a frame after an E0 prefix
        send(8'hE0);
        send(8'h75, 1'b0, 1'b0, 4);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        chk_kb("midframe_reset_kb", 16'd0);
        #3 reset = 1'b0;
        repeat (5) @(posedge clk);
        expect_ev(EV_STROBE, 16'd56);
        send(8'h75);
        chk_kb("after_reset_keypad8", 16'd56);
        expect_ev(EV_CHG, 16'd0);
        send(8'hF0); send(8'h75);

        repeat (50) @(posedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
